// File: rtl/pcs_pkg.sv
// Shared 10GBASE-R PCS receive definitions: lock states,
// sync-header codes and block-lock window constants.
package pcs_pkg;

    typedef enum logic [1:0] {
        HUNT,
        SLIP_WAIT,
        LOCKED
    } lock_state_t;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    localparam int LOCK_WINDOW  = 64;
    localparam int LOCK_INV_MAX = 16;

    function automatic logic sh_is_valid(input logic [1:0] sh);
        return (sh == SH_DATA) || (sh == SH_CTRL);
    endfunction

endpackage

// File: rtl/rx_link_ctrl_if.sv
// Gearbox <-> link controller bundle: header beats in,
// bitslip request back.
interface rx_link_ctrl_if;

    logic [1:0] i_header;
    logic       i_valid;
    logic       o_slip;

    modport master (
        output i_header,
        output i_valid,
        input  o_slip
    );

    modport slave (
        input  i_header,
        input  i_valid,
        output o_slip
    );

endinterface

// File: rtl/ber_monitor.sv
// High bit-error-rate monitor: counts invalid sync headers
// over a fixed window of header beats while enabled.
module ber_monitor #(
    parameter int BER_WINDOW = 19531,
    parameter int BER_THRESH = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_enable,
    input  logic i_valid,
    input  logic i_sh_valid,
    output logic o_hi_ber
);

    localparam int WIN_W = $clog2(BER_WINDOW + 1);
    localparam int CNT_W = $clog2(BER_THRESH + 1);

    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0] ber_cnt_q, ber_cnt_d;
    logic [CNT_W-1:0] ber_inc;
    logic             hi_ber_q, hi_ber_d;
    logic             at_thresh;

    always_comb begin
        win_cnt_d = win_cnt_q;
        ber_cnt_d = ber_cnt_q;
        hi_ber_d  = hi_ber_q;
        ber_inc   = ber_cnt_q;
        at_thresh = 1'b0;
        if (!i_enable) begin
            win_cnt_d = '0;
            ber_cnt_d = '0;
            hi_ber_d  = 1'b0;
        end else if (i_valid) begin
            if (!i_sh_valid && ber_cnt_q != CNT_W'(BER_THRESH)) begin
                ber_inc = ber_cnt_q + 1'b1;
            end
            at_thresh = (ber_inc == CNT_W'(BER_THRESH));
            // The closing beat's header still belongs to the ending window.
            if (win_cnt_q == WIN_W'(BER_WINDOW - 1)) begin
                win_cnt_d = '0;
                ber_cnt_d = '0;
                hi_ber_d  = at_thresh;
            end else begin
                win_cnt_d = win_cnt_q + 1'b1;
                ber_cnt_d = ber_inc;
                hi_ber_d  = hi_ber_q | at_thresh;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            win_cnt_q <= '0;
            ber_cnt_q <= '0;
            hi_ber_q  <= 1'b0;
        end else begin
            win_cnt_q <= win_cnt_d;
            ber_cnt_q <= ber_cnt_d;
            hi_ber_q  <= hi_ber_d;
        end
    end

    assign o_hi_ber = hi_ber_q;

endmodule

// File: rtl/rx_link_ctrl.sv
// 10GBASE-R receive block-lock FSM, bitslip control, error
// counter and link status, with the BER monitor below it.
module rx_link_ctrl #(
    parameter int SLIP_SETTLE = 4,
    parameter int BER_WINDOW  = 19531,
    parameter int BER_THRESH  = 16,
    parameter int MAX_SLIPS   = 66
) (
    input  logic           i_clk,
    input  logic           i_reset,
    rx_link_ctrl_if.slave  gb,
    input  logic           i_err_clear,
    output logic           o_block_lock,
    output logic           o_hi_ber,
    output logic           o_link_up,
    output logic           o_align_fail,
    output logic [5:0]     o_err_count
);

    import pcs_pkg::*;

    localparam int SH_W  = $clog2(LOCK_WINDOW + 1);
    localparam int INV_W = $clog2(LOCK_INV_MAX + 1);
    localparam int SET_W = $clog2(SLIP_SETTLE + 1);
    localparam int SLP_W = $clog2(MAX_SLIPS + 1);

    lock_state_t      state_q, state_d;
    logic [SH_W-1:0]  sh_cnt_q, sh_cnt_d;
    logic [INV_W-1:0] inv_cnt_q, inv_cnt_d;
    logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [SLP_W-1:0] slip_cnt_q, slip_cnt_d;
    logic             slip_q, slip_d;
    logic             align_fail_q, align_fail_d;
    logic             block_lock_q, block_lock_d;
    logic             link_up_q, link_up_d;
    logic [5:0]       err_cnt_q, err_cnt_d;
    logic             sh_ok;
    logic             do_slip;
    logic             err_inc;
    logic             hi_ber;

    assign sh_ok = sh_is_valid(gb.i_header);

    always_comb begin
        state_d      = state_q;
        sh_cnt_d     = sh_cnt_q;
        inv_cnt_d    = inv_cnt_q;
        settle_cnt_d = settle_cnt_q;
        slip_cnt_d   = slip_cnt_q;
        slip_d       = 1'b0;
        align_fail_d = 1'b0;
        block_lock_d = block_lock_q;
        err_cnt_d    = err_cnt_q;
        do_slip      = 1'b0;
        err_inc      = 1'b0;
        link_up_d    = block_lock_q & ~hi_ber;
        if (gb.i_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (!sh_ok) begin
                        do_slip = 1'b1;
                    end else if (sh_cnt_q == SH_W'(LOCK_WINDOW - 1)) begin
                        state_d      = LOCKED;
                        block_lock_d = 1'b1;
                        sh_cnt_d     = '0;
                        slip_cnt_d   = '0;
                    end else begin
                        sh_cnt_d = sh_cnt_q + 1'b1;
                    end
                end
                SLIP_WAIT: begin
                    if (settle_cnt_q == SET_W'(SLIP_SETTLE - 1)) begin
                        state_d      = HUNT;
                        settle_cnt_d = '0;
                        sh_cnt_d     = '0;
                        inv_cnt_d    = '0;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 1'b1;
                    end
                end
                LOCKED: begin
                    err_inc = ~sh_ok;
                    // Losing lock outranks the window rollover on the same beat.
                    if (!sh_ok && inv_cnt_q == INV_W'(LOCK_INV_MAX - 1)) begin
                        block_lock_d = 1'b0;
                        do_slip      = 1'b1;
                    end else if (sh_cnt_q == SH_W'(LOCK_WINDOW - 1)) begin
                        sh_cnt_d  = '0;
                        inv_cnt_d = '0;
                    end else begin
                        sh_cnt_d  = sh_cnt_q + 1'b1;
                        inv_cnt_d = inv_cnt_q + {{(INV_W-1){1'b0}}, ~sh_ok};
                    end
                end
                default: state_d = HUNT;
            endcase

            if (do_slip) begin
                slip_d       = 1'b1;
                state_d      = SLIP_WAIT;
                sh_cnt_d     = '0;
                inv_cnt_d    = '0;
                settle_cnt_d = '0;
                if (slip_cnt_q == SLP_W'(MAX_SLIPS - 1)) begin
                    align_fail_d = 1'b1;
                    slip_cnt_d   = '0;
                end else begin
                    slip_cnt_d = slip_cnt_q + 1'b1;
                end
            end

            if (i_err_clear) begin
                err_cnt_d = {5'd0, err_inc};
            end else if (err_inc && err_cnt_q != 6'd63) begin
                err_cnt_d = err_cnt_q + 6'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= HUNT;
            sh_cnt_q     <= '0;
            inv_cnt_q    <= '0;
            settle_cnt_q <= '0;
            slip_cnt_q   <= '0;
            slip_q       <= 1'b0;
            align_fail_q <= 1'b0;
            block_lock_q <= 1'b0;
            link_up_q    <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            sh_cnt_q     <= sh_cnt_d;
            inv_cnt_q    <= inv_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            slip_cnt_q   <= slip_cnt_d;
            slip_q       <= slip_d;
            align_fail_q <= align_fail_d;
            block_lock_q <= block_lock_d;
            link_up_q    <= link_up_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    ber_monitor #(
        .BER_WINDOW (BER_WINDOW),
        .BER_THRESH (BER_THRESH)
    ) u_ber (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_enable   (block_lock_q),
        .i_valid    (gb.i_valid),
        .i_sh_valid (sh_ok),
        .o_hi_ber   (hi_ber)
    );

    assign gb.o_slip    = slip_q;
    assign o_block_lock = block_lock_q;
    assign o_hi_ber     = hi_ber;
    assign o_link_up    = link_up_q;
    assign o_align_fail = align_fail_q;
    assign o_err_count  = err_cnt_q;

endmodule

// File: tb/tb_rx_link_ctrl.sv
// Bench for rx_link_ctrl: vector table, corner sequences and
// randomized traffic against a beat-level reference model.
module tb_rx_link_ctrl;

    localparam int SETTLE = 4;
    localparam int WIN    = 100;
    localparam int TH     = 16;
    localparam int MAXS   = 66;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       block_lock;
    logic       hi_ber;
    logic       link_up;
    logic       align_fail;
    logic [5:0] err_count;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model: expected outputs plus bookkeeping
    int m_lock, m_hi, m_link, m_slip, m_af, m_err;
    int run, ign, slips, win_hdrs, win_bad, ber_beats, ber_bad;

    rx_link_ctrl_if lnk ();

    always #5 clk = ~clk;

    rx_link_ctrl #(
        .SLIP_SETTLE (SETTLE),
        .BER_WINDOW  (WIN),
        .BER_THRESH  (TH),
        .MAX_SLIPS   (MAXS)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .gb           (lnk),
        .i_err_clear  (clr),
        .o_block_lock (block_lock),
        .o_hi_ber     (hi_ber),
        .o_link_up    (link_up),
        .o_align_fail (align_fail),
        .o_err_count  (err_count)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic slip_now();
        m_slip = 1;
        slips++;
        if (slips == MAXS) begin
            m_af  = 1;
            slips = 0;
        end
        ign      = SETTLE;
        run      = 0;
        win_hdrs = 0;
        win_bad  = 0;
    endtask

    task automatic model(input logic [1:0] h, input bit v,
                         input bit c, input bit r);
        bit good;
        bit bad_locked;
        int old_lock;
        int old_hi;
        if (r) begin
            m_lock = 0; m_hi = 0; m_link = 0; m_slip = 0; m_af = 0;
            m_err = 0; run = 0; ign = 0; slips = 0; win_hdrs = 0;
            win_bad = 0; ber_beats = 0; ber_bad = 0;
            return;
        end
        old_lock = m_lock;
        old_hi   = m_hi;
        good     = (h == 2'b01) || (h == 2'b10);
        m_slip   = 0;
        m_af     = 0;
        m_link   = (old_lock != 0 && old_hi == 0) ? 1 : 0;
        if (old_lock == 0) begin
            ber_beats = 0;
            ber_bad   = 0;
            m_hi      = 0;
        end else if (v) begin
            if (!good && ber_bad < TH) ber_bad++;
            if (ber_bad >= TH) m_hi = 1;
            ber_beats++;
            if (ber_beats == WIN) begin
                m_hi      = (ber_bad >= TH) ? 1 : 0;
                ber_beats = 0;
                ber_bad   = 0;
            end
        end
        if (!v) return;
        bad_locked = (old_lock != 0) && !good;
        if (c) m_err = bad_locked ? 1 : 0;
        else if (bad_locked && m_err < 63) m_err++;
        if (ign > 0) begin
            ign--;
        end else if (old_lock == 0) begin
            if (good) begin
                run++;
                if (run == 64) begin
                    m_lock = 1; run = 0; slips = 0;
                    win_hdrs = 0; win_bad = 0;
                end
            end else begin
                slip_now();
            end
        end else begin
            win_hdrs++;
            if (!good) win_bad++;
            if (win_bad == 16) begin
                m_lock = 0;
                slip_now();
            end else if (win_hdrs == 64) begin
                win_hdrs = 0;
                win_bad  = 0;
            end
        end
    endtask

    task automatic tick(input logic [1:0] h, input bit v,
                        input bit c, input bit r);
        lnk.i_header = h;
        lnk.i_valid  = v;
        clr          = c;
        rst          = r;
        model(h, v, c, r);
        @(posedge clk);
        #1;
        chk("m_block_lock", int'(block_lock), m_lock);
        chk("m_hi_ber", int'(hi_ber), m_hi);
        chk("m_link_up", int'(link_up), m_link);
        chk("m_slip", int'(lnk.o_slip), m_slip);
        chk("m_align_fail", int'(align_fail), m_af);
        chk("m_err_count", int'(err_count), m_err);
    endtask

    task automatic beats(input logic [1:0] h, input int n);
        for (int i = 0; i < n; i++) tick(h, 1'b1, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic [1:0] h;
        int         n;
        bit         lock;
        bit         slip;
        bit         hi;
        int         err;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int  slip_no;
        int  af_seen;
        bit  bad;
        int  rate;
        logic [1:0] h;

        tbl[0]  = '{2'b01, 63, 1'b0, 1'b0, 1'b0, 0};
        tbl[1]  = '{2'b01,  1, 1'b1, 1'b0, 1'b0, 0};
        tbl[2]  = '{2'b11, 15, 1'b1, 1'b0, 1'b0, 15};
        tbl[3]  = '{2'b01, 49, 1'b1, 1'b0, 1'b0, 15};
        tbl[4]  = '{2'b11, 15, 1'b1, 1'b0, 1'b1, 30};
        tbl[5]  = '{2'b11,  1, 1'b0, 1'b1, 1'b1, 31};
        tbl[6]  = '{2'b01,  4, 1'b0, 1'b0, 1'b0, 31};
        tbl[7]  = '{2'b01, 10, 1'b0, 1'b0, 1'b0, 31};
        tbl[8]  = '{2'b11,  1, 1'b0, 1'b1, 1'b0, 31};
        tbl[9]  = '{2'b01,  4, 1'b0, 1'b0, 1'b0, 31};
        tbl[10] = '{2'b01, 63, 1'b0, 1'b0, 1'b0, 31};
        tbl[11] = '{2'b01,  1, 1'b1, 1'b0, 1'b0, 31};

        // reset state
        tick(2'b00, 1'b0, 1'b0, 1'b1);
        tick(2'b00, 1'b0, 1'b0, 1'b1);
        chk("rst_lock", int'(block_lock), 0);
        chk("rst_slip", int'(lnk.o_slip), 0);
        chk("rst_err", int'(err_count), 0);

        // table-driven segments
        for (int i = 0; i < 12; i++) begin
            beats(tbl[i].h, tbl[i].n);
            chk($sformatf("tbl%0d_lock", i), int'(block_lock), int'(tbl[i].lock));
            chk($sformatf("tbl%0d_slip", i), int'(lnk.o_slip), int'(tbl[i].slip));
            chk($sformatf("tbl%0d_hi", i), int'(hi_ber), int'(tbl[i].hi));
            chk($sformatf("tbl%0d_err", i), int'(err_count), tbl[i].err);
        end

        // A: lock then link_up one clock later; idle beats stall
        tick(2'b00, 1'b0, 1'b0, 1'b1);
        beats(2'b10, 64);
        chk("A_lock", int'(block_lock), 1);
        chk("A_link_early", int'(link_up), 0);
        tick(2'b11, 1'b0, 1'b0, 1'b0);
        chk("A_link", int'(link_up), 1);
        for (int i = 0; i < 5; i++) tick(2'b11, 1'b0, 1'b0, 1'b0);
        chk("A_idle_err", int'(err_count), 0);

        // B: invalid-only headers, align_fail on slip 66 and 132
        tick(2'b00, 1'b0, 1'b0, 1'b1);
        af_seen = 0;
        for (slip_no = 1; slip_no <= 132; slip_no++) begin
            tick(2'b11, 1'b1, 1'b0, 1'b0);
            chk("B_slip", int'(lnk.o_slip), 1);
            chk("B_align", int'(align_fail),
                (slip_no == 66 || slip_no == 132) ? 1 : 0);
            if (align_fail) af_seen++;
            beats(2'b00, SETTLE);
            chk("B_slip_clear", int'(lnk.o_slip), 0);
        end
        chk("B_af_count", af_seen, 2);

        // C: BER spread vs concentrated, then recovery
        tick(2'b00, 1'b0, 1'b0, 1'b1);
        beats(2'b01, 64);
        for (int b = 0; b < 600; b++) begin
            bad = (b < 400 && ((b % 100) == 10 || (b % 100) == 30 ||
                               (b % 100) == 50 || (b % 100) == 70)) ||
                  (b >= 440 && b <= 455);
            tick(bad ? 2'b11 : 2'b01, 1'b1, 1'b0, 1'b0);
            if (b == 399) chk("C_spread_hi", int'(hi_ber), 0);
            if (b == 454) chk("C_pre_hi", int'(hi_ber), 0);
            if (b == 455) chk("C_hi_set", int'(hi_ber), 1);
            if (b == 456) chk("C_link_down", int'(link_up), 0);
            if (b == 598) chk("C_hi_hold", int'(hi_ber), 1);
            if (b == 599) chk("C_hi_clear", int'(hi_ber), 0);
        end
        chk("C_lock_kept", int'(block_lock), 1);

        // D: error counter saturation and clear-with-increment
        tick(2'b00, 1'b0, 1'b0, 1'b1);
        beats(2'b01, 64);
        for (int r = 0; r < 5; r++) begin
            beats(2'b11, 15);
            beats(2'b01, 49);
        end
        chk("D_sat", int'(err_count), 63);
        chk("D_lock", int'(block_lock), 1);
        tick(2'b00, 1'b1, 1'b1, 1'b0);
        chk("D_clr_inc", int'(err_count), 1);

        // E: unlock into SLIP_WAIT, then reset mid-settle
        beats(2'b11, 15);
        chk("E_unlock", int'(block_lock), 0);
        chk("E_slip", int'(lnk.o_slip), 1);
        beats(2'b01, 2);
        tick(2'b01, 1'b1, 1'b0, 1'b1);
        chk("E_rst_err", int'(err_count), 0);
        chk("E_rst_lock", int'(block_lock), 0);
        chk("E_rst_slip", int'(lnk.o_slip), 0);
        chk("E_rst_link", int'(link_up), 0);
        beats(2'b01, 63);
        chk("E_nolock63", int'(block_lock), 0);
        beats(2'b01, 1);
        chk("E_lock64", int'(block_lock), 1);

        // randomized traffic against the model
        tick(2'b00, 1'b0, 1'b0, 1'b1);
        for (int ch = 0; ch < 40; ch++) begin
            case (ch % 4)
                0: rate = 0;
                1: rate = 3;
                2: rate = 50;
                default: rate = 300;
            endcase
            for (int k = 0; k < 500; k++) begin
                bad = ($urandom_range(0, 999) < rate);
                if (bad) h = $urandom_range(0, 1) ? 2'b11 : 2'b00;
                else     h = $urandom_range(0, 1) ? 2'b10 : 2'b01;
                tick(h, $urandom_range(0, 9) < 8,
                     $urandom_range(0, 99) == 0,
                     $urandom_range(0, 1999) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
